fifo_axis_reader: RTL

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

---
 rtl/fifo_axis_reader.sv | 95 +++++++++
 1 files changed

// File: rtl/fifo_axis_reader.sv
// Pops a latency-RD_LAT source FIFO and re-presents the words as an AXI-Stream master.
// A skid buffer sized for all in-flight reads keeps the stream lossless under backpressure.
module fifo_axis_reader #(
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned BUF_D  = 4
) (
  input  logic                       clk_a_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       fifo_empty_i,
  output logic                       fifo_pop_o,
  output logic                       fifo_rd_en_o,
  input  logic [DW-1:0]              fifo_dt_i,
  output logic [DW-1:0]              m_axis_tdata_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [$clog2(BUF_D):0]     occ_o
);

  localparam int unsigned AW = $clog2(BUF_D);
  localparam int unsigned OW = AW + 1;

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [RD_LAT-1:0]  infl_q, infl_d;
  logic [DW-1:0]      mem_q [BUF_D];
  logic               started_q;

  logic hs;
  logic room;
  logic capture;
  logic wr_en;

  assign m_axis_tvalid_o = (wr_ptr_q != rd_ptr_q);
  assign m_axis_tdata_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign hs              = m_axis_tvalid_o & m_axis_tready_i;

  // Occupancy counts in-flight words too, so a full count only admits a pop when a word leaves.
  assign room       = (occ_q < OW'(BUF_D)) | ((occ_q == OW'(BUF_D)) & hs);
  assign fifo_pop_o = started_q & en_i & ~fifo_empty_i & ~flush_i & room;

  assign capture      = infl_q[RD_LAT-1];
  assign wr_en        = capture & ~flush_i;
  assign fifo_rd_en_o = (|infl_q) | fifo_pop_o;
  assign occ_o        = occ_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    infl_d   = infl_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      infl_d   = '0;
    end else begin
      infl_d    = infl_q << 1;
      infl_d[0] = fifo_pop_o;
      wr_ptr_d  = wr_ptr_q + (AW + 1)'(capture);
      rd_ptr_d  = rd_ptr_q + (AW + 1)'(hs);
      occ_d     = occ_q + OW'(fifo_pop_o) - OW'(hs);
    end
  end

  always_ff @(posedge clk_a_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      infl_q    <= '0;
      started_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      infl_q    <= infl_d;
      started_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_a_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BUF_D; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= fifo_dt_i;
    end
  end

endmodule
